// File: rtl/ps2_rx_ctrl_if.sv
// Receive-side bus from the PS/2 controller to the keyboard matrix block.
// The controller drives it through the master modport; the consumer reads it through slave.
interface ps2_rx_ctrl_if;
  logic [7:0] ps2_data;
  logic       ps2_data_clk;
  logic       ps2_ext;
  logic       ps2_err;

  modport master (
    output ps2_data,
    output ps2_data_clk,
    output ps2_ext,
    output ps2_err
  );

  modport slave (
    input ps2_data,
    input ps2_data_clk,
    input ps2_ext,
    input ps2_err
  );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 host receiver: synchronise and filter the device clock, deframe 11-bit frames, strobe good bytes.
// Optional macro PS2_E0_FILTER_EN swallows E0 prefixes and tags the following bytes with ps2_ext.
module ps2_rx_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_rx_ctrl_if.master rx
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic clkMeta_q, clkSync_q;
  logic datMeta_q, datSync_q;

  logic           filtClk_q, filtClk_d;
  logic [FCW-1:0] filtCnt_q, filtCnt_d;
  logic           fallEvt;

  state_e         state_q;
  logic [2:0]     bitCnt_q;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [TCW-1:0] timeoutCnt_q;
  logic           timeoutHit;
  logic           parityOk;

  logic [7:0] data_q;
  logic       strobe_q;
  logic       err_q;
`ifdef PS2_E0_FILTER_EN
  logic       extFlag_q;
  logic       ext_q;
`endif

  // Idle level of both lines is high, so the synchronisers reset to 1.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      clkMeta_q <= 1'b1;
      clkSync_q <= 1'b1;
      datMeta_q <= 1'b1;
      datSync_q <= 1'b1;
    end else begin
      clkMeta_q <= ps2_clk;
      clkSync_q <= clkMeta_q;
      datMeta_q <= ps2_dat;
      datSync_q <= datMeta_q;
    end
  end

  always_comb begin
    filtClk_d = filtClk_q;
    filtCnt_d = '0;
    if (clkSync_q != filtClk_q) begin
      if (filtCnt_q == FILT_LAST) begin
        filtClk_d = clkSync_q;
      end else begin
        filtCnt_d = filtCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      filtClk_q <= 1'b1;
      filtCnt_q <= '0;
    end else begin
      filtClk_q <= filtClk_d;
      filtCnt_q <= filtCnt_d;
    end
  end

  // The fall is seen in the same cycle the filter decides to toggle, so datSync_q is sampled alongside it.
  assign fallEvt    = filtClk_q & ~filtClk_d;
  assign timeoutHit = (state_q != IDLE) && !fallEvt && (timeoutCnt_q == TO_LAST);
  assign parityOk   = ^{shift_q, parity_q};

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      timeoutCnt_q <= '0;
      data_q       <= '0;
      strobe_q     <= 1'b0;
      err_q        <= 1'b0;
`ifdef PS2_E0_FILTER_EN
      extFlag_q    <= 1'b0;
      ext_q        <= 1'b0;
`endif
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;

      if (fallEvt || (state_q == IDLE) || timeoutHit) begin
        timeoutCnt_q <= '0;
      end else begin
        timeoutCnt_q <= timeoutCnt_q + 1'b1;
      end

      if (timeoutHit) begin
        state_q <= IDLE;
        err_q   <= 1'b1;
`ifdef PS2_E0_FILTER_EN
        extFlag_q <= 1'b0;
`endif
      end else if (fallEvt) begin
        unique case (state_q)
          IDLE: begin
            if (!datSync_q) begin
              state_q  <= DATA;
              bitCnt_q <= '0;
            end
          end
          DATA: begin
            shift_q  <= {datSync_q, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            parity_q <= datSync_q;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (datSync_q && parityOk) begin
`ifdef PS2_E0_FILTER_EN
              if (shift_q == 8'hE0) begin
                extFlag_q <= 1'b1;
              end else begin
                data_q   <= shift_q;
                strobe_q <= 1'b1;
                ext_q    <= extFlag_q;
                if (shift_q != 8'hF0) begin
                  extFlag_q <= 1'b0;
                end
              end
`else
              data_q   <= shift_q;
              strobe_q <= 1'b1;
`endif
            end else begin
              err_q <= 1'b1;
`ifdef PS2_E0_FILTER_EN
              extFlag_q <= 1'b0;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx.ps2_data     = data_q;
  assign rx.ps2_data_clk = strobe_q;
  assign rx.ps2_err      = err_q;
`ifdef PS2_E0_FILTER_EN
  assign rx.ps2_ext      = ext_q;
`else
  assign rx.ps2_ext      = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: directed frames from the test plan plus random frames,
// checked against a byte-level model of what the keyboard matrix block should see.
module tb_ps2_rx_ctrl;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 3000;
`ifdef PS2_E0_FILTER_EN
  localparam bit E0_EN = 1'b1;
`else
  localparam bit E0_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_dat  = 1'b1;

  ps2_rx_ctrl_if rxBus ();

  ps2_rx_ctrl #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx      (rxBus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int unsigned cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checkCount = 0;
  int passCount  = 0;

  logic [8:0]  obsQ[$];
  int unsigned obsCyc[$];
  int          errSeen    = 0;
  int unsigned lastErrCyc = 0;
  int          dblStrobe  = 0;
  logic        prevStrobe = 1'b0;

  always @(negedge CLOCK_50) begin
    if (rxBus.ps2_data_clk) begin
      obsQ.push_back({rxBus.ps2_ext, rxBus.ps2_data});
      obsCyc.push_back(cyc);
      if (prevStrobe) dblStrobe++;
    end
    if (rxBus.ps2_err) begin
      errSeen++;
      lastErrCyc = cyc;
    end
    prevStrobe = rxBus.ps2_data_clk;
  end

  // Byte-level model: what the consumer must see for each frame, independent of timing.
  logic [8:0]  expQ[$];
  int          expErr      = 0;
  logic [7:0]  lastData    = 8'h00;
  bit          extFlag     = 1'b0;
  int unsigned lastFallCyc = 0;

  function automatic void modelFrame(input logic [7:0] b, input bit good);
    if (!good) begin
      expErr++;
      extFlag = 1'b0;
      return;
    end
    if (E0_EN && b == 8'hE0) begin
      extFlag = 1'b1;
      return;
    end
    expQ.push_back({E0_EN ? extFlag : 1'b0, b});
    lastData = b;
    if (b != 8'hF0) extFlag = 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Drives the first nBits of a frame as a device would; glitchAfter inserts a 3-cycle low pulse.
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit stopBit,
                               input int nBits, input int glitchAfter, input int halfPer);
    logic [10:0] fr;
    fr = {stopBit, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(negedge CLOCK_50);
      ps2_dat = fr[i];
      waitCyc(halfPer);
      ps2_clk     = 1'b0;
      lastFallCyc = cyc;
      waitCyc(halfPer);
      ps2_clk = 1'b1;
      if (i == glitchAfter) begin
        waitCyc(halfPer / 2);
        ps2_clk = 1'b0;
        waitCyc(3);
        ps2_clk = 1'b1;
      end
    end
    waitCyc(halfPer);
    ps2_dat = 1'b1;
    waitCyc(halfPer);
  endtask

  task automatic verifyAll();
    @(posedge CLOCK_50);
    #1;
    checkOutput("strobeCount", obsQ.size(), expQ.size());
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      checkOutput("byteExt", obsQ.pop_front(), expQ.pop_front());
    end
    obsQ.delete();
    expQ.delete();
    obsCyc.delete();
    checkOutput("errCount", errSeen, expErr);
    errSeen = 0;
    expErr  = 0;
    checkOutput("dataHold", rxBus.ps2_data, lastData);
    checkOutput("noDoubleStrobe", dblStrobe, 0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstData", rxBus.ps2_data, 8'h00);
    checkOutput("rstStrobe", rxBus.ps2_data_clk, 1'b0);
    checkOutput("rstExt", rxBus.ps2_ext, 1'b0);
    checkOutput("rstErr", rxBus.ps2_err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  b;
    bit          badPar;
    bit          stopBit;
    int          hp;
    int unsigned lat;
    bit          inWindow;
    logic [7:0]  seqBytes[4];

    RESET_N = 1'b0;
    waitCyc(4);
    checkResetOutputs();
    RESET_N = 1'b1;
    waitCyc(4);

    // Good 0x1C; strobe lands one cycle after the internal fall event, i.e. 2 sync + FILTER_LEN cycles after the pin drops.
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1, 40);
    modelFrame(8'h1C, 1'b1);
    lat = (obsCyc.size() > 0) ? obsCyc[0] - lastFallCyc : 0;
    checkOutput("strobeLatency", lat, FILTER_LEN + 2);
    verifyAll();

    applyStimulus(8'h1C, 1'b1, 1'b1, 11, -1, 40);
    modelFrame(8'h1C, 1'b0);
    verifyAll();
    applyStimulus(8'h29, 1'b0, 1'b1, 11, -1, 40);
    modelFrame(8'h29, 1'b1);
    verifyAll();

    applyStimulus(8'h5A, 1'b0, 1'b0, 11, -1, 40);
    modelFrame(8'h5A, 1'b0);
    verifyAll();
    applyStimulus(8'h33, 1'b0, 1'b1, 11, -1, 40);
    modelFrame(8'h33, 1'b1);
    verifyAll();

    // Start plus four data bits, then the device goes quiet.
    applyStimulus(8'hA5, 1'b0, 1'b1, 5, -1, 30);
    for (int k = 0; k < TIMEOUT_CYCLES + 200 && errSeen == 0; k++) @(negedge CLOCK_50);
    lat      = lastErrCyc - lastFallCyc;
    inWindow = (errSeen > 0) && (lat >= TIMEOUT_CYCLES) && (lat <= TIMEOUT_CYCLES + FILTER_LEN + 4);
    checkOutput("timeoutWindow", inWindow, 1'b1);
    modelFrame(8'h00, 1'b0);
    verifyAll();
    applyStimulus(8'hF0, 1'b0, 1'b1, 11, -1, 40);
    modelFrame(8'hF0, 1'b1);
    verifyAll();

    @(negedge CLOCK_50);
    ps2_clk = 1'b0;
    waitCyc(3);
    ps2_clk = 1'b1;
    waitCyc(40);
    verifyAll();
    applyStimulus(8'h12, 1'b0, 1'b1, 11, 4, 40);
    modelFrame(8'h12, 1'b1);
    verifyAll();

    seqBytes = '{8'hE0, 8'hF0, 8'h75, 8'h1A};
    foreach (seqBytes[i]) begin
      applyStimulus(seqBytes[i], 1'b0, 1'b1, 11, -1, 30);
      modelFrame(seqBytes[i], 1'b1);
    end
    verifyAll();

    // A pending E0 prefix plus a partial frame, both wiped by reset.
    applyStimulus(8'hE0, 1'b0, 1'b1, 11, -1, 30);
    modelFrame(8'hE0, 1'b1);
    applyStimulus(8'h3C, 1'b0, 1'b1, 6, -1, 30);
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    waitCyc(3);
    checkResetOutputs();
    RESET_N  = 1'b1;
    lastData = 8'h00;
    extFlag  = 1'b0;
    waitCyc(5);
    verifyAll();
    applyStimulus(8'h6B, 1'b0, 1'b1, 11, -1, 30);
    modelFrame(8'h6B, 1'b1);
    verifyAll();

    repeat (20) begin
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) b = 8'hE0;
      else if ($urandom_range(0, 5) == 0) b = 8'hF0;
      badPar  = ($urandom_range(0, 7) == 0);
      stopBit = ($urandom_range(0, 7) != 0);
      hp      = $urandom_range(15, 40);
      applyStimulus(b, badPar, stopBit, 11, -1, hp);
      modelFrame(b, !badPar && stopBit);
      verifyAll();
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
